// File: rtl/sobel_pkg.sv
// sobel_pkg: shared sequencer states, default frame geometry and counter width helper
//   Used by sobel_frame_ctrl and the Sobel core.
package sobel_pkg;
    typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, END} state_t;
    localparam int DEF_IMG_WIDTH = 720;
    localparam int DEF_IMG_HEIGHT = 540;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// sobel_frame_ctrl_if: FIFO/core handshake bundle around the Sobel core
//   master: frame controller (drives gated FIFO read/write and gated empty/full)
//   slave:  FIFOs and core (drive raw empty/full and core requests)
interface sobel_frame_ctrl_if;
    logic src_empty;
    logic src_rd_en;
    logic core_in_empty;
    logic core_in_rd_en;
    logic dst_full;
    logic dst_wr_en;
    logic core_out_full;
    logic core_out_wr_en;
    modport master (
        input  src_empty, core_in_rd_en, dst_full, core_out_wr_en,
        output src_rd_en, core_in_empty, dst_wr_en, core_out_full
    );
    modport slave (
        output src_empty, core_in_rd_en, dst_full, core_out_wr_en,
        input  src_rd_en, core_in_empty, dst_wr_en, core_out_full
    );
endinterface

// File: rtl/sobel_stall_timer.sv
// sobel_stall_timer: counts consecutive write-less cycles while enabled
//   clock, reset: clock and synchronous active-high reset
//   clear:   zero the count (frame restart)
//   enable:  count only while draining
//   write:   an output write happened this cycle (restarts the count)
//   expired: this is the TIMEOUT-th consecutive idle cycle
module sobel_stall_timer #(
    parameter int TIMEOUT = 65535
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic write,
    output logic expired
);
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_cnt;
    always_ff @(posedge clock) begin
        if (reset || clear || (enable && write))
            stall_cnt <= '0;
        else if (enable)
            stall_cnt <= stall_cnt + 1'b1;
    end
    assign expired = enable && !write && stall_cnt == SW'(TIMEOUT - 1);
endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer gating the Sobel core's FIFO handshakes
//   clock, reset  : clock, synchronous active-high reset
//   start, frames : begin a run of 'frames' frames (ignored when 0 or busy)
//   abort         : cancel the run, back to IDLE next cycle
//   busy, done, error, frame_count : run status; done pulses once per run,
//                   error is a sticky drain timeout
//   core_reset    : held high in IDLE and for one FLUSH cycle between frames
//   fifo          : gated FIFO/core handshakes (master side)
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH     = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT    = DEF_IMG_HEIGHT,
    parameter int IN_PER_FRAME  = IMG_WIDTH * IMG_HEIGHT,
    parameter int OUT_PER_FRAME = IMG_WIDTH * IMG_HEIGHT,
    parameter int TIMEOUT       = 65535,
    parameter int CW            = cnt_width(IN_PER_FRAME)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  frames,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] frame_count,
    output logic        core_reset,
    sobel_frame_ctrl_if.master fifo
);
    localparam int OW = cnt_width(OUT_PER_FRAME);
    state_t        state;
    logic [7:0]    frames_left;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] in_nxt;
    logic [OW-1:0] out_cnt;
    logic [OW-1:0] out_nxt;
    logic          in_gate;
    logic          out_gate;
    logic          in_hit;
    logic          out_hit;
    logic          expired;
    assign in_gate  = state == RUN && in_cnt < CW'(IN_PER_FRAME);
    assign out_gate = (state == RUN || state == DRAIN) && out_cnt < OW'(OUT_PER_FRAME);
    assign fifo.src_rd_en     = fifo.core_in_rd_en & in_gate;
    assign fifo.core_in_empty = fifo.src_empty | ~in_gate;
    assign fifo.dst_wr_en     = fifo.core_out_wr_en & out_gate;
    assign fifo.core_out_full = fifo.dst_full | ~out_gate;
    // Transitions look at the counts as they will be after this cycle's transfers
    assign in_nxt  = in_cnt + CW'(fifo.src_rd_en);
    assign out_nxt = out_cnt + OW'(fifo.dst_wr_en);
    assign in_hit  = in_nxt == CW'(IN_PER_FRAME);
    assign out_hit = out_nxt == OW'(OUT_PER_FRAME);
    sobel_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == FLUSH),
        .enable  (state == DRAIN),
        .write   (fifo.dst_wr_en),
        .expired (expired)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            frame_count <= '0;
            core_reset  <= 1'b1;
            frames_left <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state      <= IDLE;
                busy       <= 1'b0;
                core_reset <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort && frames != 8'd0) begin
                            state       <= FLUSH;
                            busy        <= 1'b1;
                            frames_left <= frames;
                            error       <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        in_cnt     <= '0;
                        out_cnt    <= '0;
                        state      <= RUN;
                        core_reset <= 1'b0;
                    end
                    RUN: begin
                        in_cnt  <= in_nxt;
                        out_cnt <= out_nxt;
                        if (in_hit)
                            state <= out_hit ? END : DRAIN;
                    end
                    DRAIN: begin
                        out_cnt <= out_nxt;
                        if (out_hit) begin
                            state <= END;
                        end else if (expired) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            core_reset <= 1'b1;
                            error      <= 1'b1;
                        end
                    end
                    END: begin
                        frame_count <= frame_count + 16'd1;
                        frames_left <= frames_left - 8'd1;
                        core_reset  <= 1'b1;
                        if (frames_left == 8'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= FLUSH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: randomized core/FIFO traffic checked against a counting reference model
module tb_sobel_frame_ctrl;
    localparam int IN_N  = 12;
    localparam int OUT_N = 2;
    localparam int TMO   = 16;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  frames = 8'd0;
    logic        busy;
    logic        done;
    logic        error;
    logic        core_reset;
    logic [15:0] frame_count;
    int checks = 0;
    int errors = 0;
    int m_phase = 0;
    int m_left = 0;
    int m_rd = 0;
    int m_wr = 0;
    int m_quiet = 0;
    int m_fc = 0;
    logic m_err = 1'b0;
    logic m_done = 1'b0;
    int wr_mode = 1;
    int bp_left = 0;
    int n_rd, n_wr, n_done, n_flush;
    int saved_fc;
    sobel_frame_ctrl_if bus ();
    sobel_frame_ctrl #(
        .IMG_WIDTH(4), .IMG_HEIGHT(3), .IN_PER_FRAME(IN_N), .OUT_PER_FRAME(OUT_N), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .frames(frames),
        .busy(busy), .done(done), .error(error), .frame_count(frame_count),
        .core_reset(core_reset), .fifo(bus)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic clear_tallies();
        n_rd = 0;
        n_wr = 0;
        n_done = 0;
        n_flush = 0;
    endtask
    task automatic tick();
        logic rd, wr, in_ok, out_ok, drain;
        drain = m_phase == 2 && m_rd == IN_N;
        bus.src_empty = $urandom_range(0, 3) == 0;
        bus.dst_full = (drain && bp_left > 0) || (wr_mode == 1 && $urandom_range(0, 3) == 0);
        if (drain && bp_left > 0) bp_left--;
        bus.core_in_rd_en = $urandom_range(0, 1) == 1;
        #1;
        bus.core_out_wr_en = wr_mode == 1 ? ($urandom_range(0, 3) != 0) :
                             wr_mode == 2 ? (drain && !bus.core_out_full) : 1'b0;
        #1;
        in_ok  = m_phase == 2 && m_rd < IN_N;
        out_ok = m_phase == 2 && m_wr < OUT_N;
        rd = bus.core_in_rd_en && in_ok;
        wr = bus.core_out_wr_en && out_ok;
        check("src_rd_en", bus.src_rd_en, rd);
        check("dst_wr_en", bus.dst_wr_en, wr);
        check("core_in_empty", bus.core_in_empty, bus.src_empty || !in_ok);
        check("core_out_full", bus.core_out_full, bus.dst_full || !out_ok);
        check("busy", busy, m_phase != 0);
        check("core_reset", core_reset, m_phase <= 1);
        check("done", done, m_done);
        check("error", error, m_err);
        check("frame_count", frame_count, 32'(m_fc & 16'hffff));
        n_rd += int'(bus.src_rd_en);
        n_wr += int'(bus.dst_wr_en);
        n_done += int'(done);
        n_flush += int'(busy && core_reset);
        m_done = 1'b0;
        if (reset) begin
            m_phase = 0; m_fc = 0; m_err = 1'b0; m_rd = 0; m_wr = 0; m_quiet = 0;
        end else if (abort && m_phase != 0) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (start && !abort && frames != 0) begin
                m_phase = 1; m_left = int'(frames); m_err = 1'b0;
            end
        end else if (m_phase == 1) begin
            m_rd = 0; m_wr = 0; m_quiet = 0; m_phase = 2;
        end else if (m_phase == 3) begin
            m_fc++;
            m_left--;
            m_done = m_left == 0;
            m_phase = m_left == 0 ? 0 : 1;
        end else begin
            if (m_rd == IN_N) begin
                if (m_wr + int'(wr) == OUT_N) m_phase = 3;
                else if (!wr && m_quiet == TMO - 1) begin m_phase = 0; m_err = 1'b1; end
                m_quiet = wr ? 0 : m_quiet + 1;
            end else if (m_rd + int'(rd) == IN_N && m_wr + int'(wr) == OUT_N) begin
                m_phase = 3;
            end
            m_rd += int'(rd);
            m_wr += int'(wr);
        end
        @(negedge clock);
    endtask
    task automatic launch(input logic [7:0] f);
        frames = f;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic run_to_idle(input string tag, input int limit);
        int i = 0;
        while (m_phase != 0 && i < limit) begin
            tick();
            i++;
        end
        tick();
        tick();
        check(tag, busy, 1'b0);
    endtask
    initial begin
        bus.src_empty = 1'b1;
        bus.dst_full = 1'b0;
        bus.core_in_rd_en = 1'b1;
        bus.core_out_wr_en = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_frame_count", frame_count, 0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_src_rd_en", bus.src_rd_en, 1'b0);
        check("rst_dst_wr_en", bus.dst_wr_en, 1'b0);
        check("rst_core_in_empty", bus.core_in_empty, 1'b1);
        check("rst_core_out_full", bus.core_out_full, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        tick();
        clear_tallies();
        launch(8'd1);
        run_to_idle("single_end", 400);
        check("single_reads", n_rd, IN_N);
        check("single_writes", n_wr, OUT_N);
        check("single_done", n_done, 1);
        check("single_fc", frame_count, 1);
        clear_tallies();
        launch(8'd3);
        repeat (4) tick();
        frames = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_idle("three_end", 1200);
        check("three_reads", n_rd, 3 * IN_N);
        check("three_writes", n_wr, 3 * OUT_N);
        check("three_done", n_done, 1);
        check("three_flush", n_flush, 3);
        check("three_fc", frame_count, 4);
        clear_tallies();
        wr_mode = 2;
        bp_left = 10;
        launch(8'd1);
        run_to_idle("bp_end", 400);
        check("bp_error", error, 1'b0);
        check("bp_writes", n_wr, OUT_N);
        check("bp_done", n_done, 1);
        check("bp_fc", frame_count, 5);
        clear_tallies();
        wr_mode = 0;
        launch(8'd1);
        run_to_idle("tmo_end", 400);
        check("tmo_error", error, 1'b1);
        check("tmo_done", n_done, 0);
        check("tmo_fc", frame_count, 5);
        wr_mode = 1;
        launch(8'd1);
        check("tmo_clear", error, 1'b0);
        run_to_idle("tmo_rerun", 400);
        check("tmo_rerun_fc", frame_count, 6);
        clear_tallies();
        launch(8'd2);
        for (int i = 0; i < 300 && !(m_phase == 2 && m_rd == 5); i++) tick();
        check("abort_reach", n_rd, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_core_reset", core_reset, 1'b1);
        tick();
        check("abort_done", n_done, 0);
        check("abort_fc", frame_count, 6);
        clear_tallies();
        launch(8'd0);
        tick();
        check("zero_busy", busy, 1'b0);
        check("zero_flush", n_flush, 0);
        wr_mode = 0;
        launch(8'd2);
        for (int i = 0; i < 300 && !(m_phase == 2 && m_rd == IN_N); i++) tick();
        repeat (3) tick();
        check("rst_mid_busy_pre", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_core_reset", core_reset, 1'b1);
        check("rst_mid_fc", frame_count, 0);
        check("rst_mid_error", error, 1'b0);
        check("rst_mid_done", done, 1'b0);
        tick();
        wr_mode = 1;
        for (int r = 0; r < 3; r++) begin
            int f;
            f = $urandom_range(1, 3);
            saved_fc = m_fc;
            clear_tallies();
            launch(8'(f));
            run_to_idle("rand_end", 1500);
            check("rand_reads", n_rd, f * IN_N);
            check("rand_writes", n_wr, f * OUT_N);
            check("rand_fc", frame_count, 16'(saved_fc + f));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
